// File: rtl/traffic_pkg.sv
// Shared types and light codes for the two-road junction controller.
package traffic_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned LIGHT_W = 6;

    typedef enum logic [PHASE_W-1:0] {
        HW_GREEN    = 3'd0,
        HW_YELLOW   = 3'd1,
        ALL_RED_A   = 3'd2,
        SW_GREEN    = 3'd3,
        SW_YELLOW   = 3'd4,
        ALL_RED_B   = 3'd5,
        NIGHT_FLASH = 3'd6
    } state_t;

    // Light codes are {hwr,hwy,hwg,swr,swy,swg}.
    localparam logic [LIGHT_W-1:0] HW_GO      = 6'b001100;
    localparam logic [LIGHT_W-1:0] HW_CAUTION = 6'b010100;
    localparam logic [LIGHT_W-1:0] CLEAR      = 6'b100100;
    localparam logic [LIGHT_W-1:0] SW_GO      = 6'b100001;
    localparam logic [LIGHT_W-1:0] SW_CAUTION = 6'b100010;

endpackage

// File: rtl/traffic_phase_timer.sv
// Time-in-phase counter: clear/enable, saturating at all-ones, with a reached-limit flag.
module traffic_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit = (cnt >= limit);

endmodule

// File: rtl/traffic_ctrl_param.sv
// Highway/side-road junction controller with latched side requests and extendable side green.
// Optional night flashing mode is enabled by defining TRAFFIC_NIGHT_FLASH_EN.
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned HW_MIN_GREEN = 8,
    parameter int unsigned YELLOW       = 3,
    parameter int unsigned ALL_RED      = 1,
    parameter int unsigned SW_MIN_GREEN = 4,
    parameter int unsigned SW_MAX_GREEN = 10,
    parameter int unsigned FLASH_HALF   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               veh,
`ifdef TRAFFIC_NIGHT_FLASH_EN
    input  logic               night,
`endif
    output logic               hwr,
    output logic               hwy,
    output logic               hwg,
    output logic               swr,
    output logic               swy,
    output logic               swg,
    output logic [PHASE_W-1:0] phase,
    output logic               cycle_done
);

    localparam logic [CNT_W-1:0] L_HW    = CNT_W'(HW_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] L_Y     = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] L_AR    = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] L_SWMIN = CNT_W'(SW_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] L_SWMAX = CNT_W'(SW_MAX_GREEN - 1);

    if (HW_MIN_GREEN == 0 || YELLOW == 0 || ALL_RED == 0 || SW_MIN_GREEN == 0 ||
        SW_MAX_GREEN < SW_MIN_GREEN || FLASH_HALF == 0) begin : g_bad_params
        $error("traffic_ctrl_param: invalid duration parameters");
    end

    state_t               state_q;
    state_t               state_d;
    logic                 req_q;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     limit;
    logic                 hit;
    logic [LIGHT_W-1:0]   lights;
    logic                 veh_live;
    logic                 suppress_done;

`ifdef TRAFFIC_NIGHT_FLASH_EN
    localparam logic [CNT_W-1:0] L_FLASH = CNT_W'(FLASH_HALF - 1);

    logic             flash_on;
    logic             night_ret;
    logic [CNT_W-1:0] flash_cnt;

    assign veh_live      = veh && (state_q != NIGHT_FLASH);
    assign suppress_done = night_ret;

    // Flash phase generator and "returning from night" marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            flash_on  <= 1'b1;
            flash_cnt <= '0;
            night_ret <= 1'b0;
        end else begin
            if (state_q != NIGHT_FLASH) begin
                flash_on  <= 1'b1;
                flash_cnt <= '0;
            end else if (flash_cnt == L_FLASH) begin
                flash_on  <= ~flash_on;
                flash_cnt <= '0;
            end else begin
                flash_cnt <= flash_cnt + CNT_W'(1);
            end
            if (state_q == NIGHT_FLASH && state_d == ALL_RED_B) begin
                night_ret <= 1'b1;
            end else if (state_q == ALL_RED_B && state_d != ALL_RED_B) begin
                night_ret <= 1'b0;
            end
        end
    end
`else
    assign veh_live      = veh;
    assign suppress_done = 1'b0;
`endif

    traffic_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_d != state_q),
        .en    (1'b1),
        .limit (limit),
        .cnt   (cnt),
        .hit   (hit)
    );

    // Next-state, timer limit and light decode.
    always_comb begin
        state_d = state_q;
        limit   = L_HW;
        lights  = CLEAR;
        case (state_q)
            HW_GREEN: begin
                lights = HW_GO;
                limit  = L_HW;
                if (hit && (req_q || veh)) begin
                    state_d = HW_YELLOW;
                end
`ifdef TRAFFIC_NIGHT_FLASH_EN
                else if (night && !req_q && !veh) begin
                    state_d = NIGHT_FLASH;
                end
`endif
            end
            HW_YELLOW: begin
                lights = HW_CAUTION;
                limit  = L_Y;
                if (hit) state_d = ALL_RED_A;
            end
            ALL_RED_A: begin
                lights = CLEAR;
                limit  = L_AR;
                if (hit) state_d = SW_GREEN;
            end
            SW_GREEN: begin
                lights = SW_GO;
                limit  = L_SWMAX;
                if (hit || ((cnt >= L_SWMIN) && !veh)) state_d = SW_YELLOW;
            end
            SW_YELLOW: begin
                lights = SW_CAUTION;
                limit  = L_Y;
                if (hit) state_d = ALL_RED_B;
            end
            ALL_RED_B: begin
                lights = CLEAR;
                limit  = L_AR;
                if (hit) state_d = HW_GREEN;
            end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            NIGHT_FLASH: begin
                lights = {1'b0, flash_on, 1'b0, flash_on, 2'b00};
                if (!night) state_d = ALL_RED_B;
            end
`endif
            default: begin
                lights  = CLEAR;
                state_d = HW_GREEN;
            end
        endcase
    end

    // State register, side-road request latch and cycle-complete pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HW_GREEN;
            req_q      <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_done <= (state_q == ALL_RED_B) && (state_d == HW_GREEN) && !suppress_done;
            if (state_q != SW_GREEN && state_d == SW_GREEN) begin
                req_q <= 1'b0;
            end else if (veh_live && state_q != SW_GREEN) begin
                req_q <= 1'b1;
            end
        end
    end

    assign {hwr, hwy, hwg, swr, swy, swg} = lights;
    assign phase = state_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Scoreboard bench for traffic_ctrl_param: phase-level reference model plus phase run-length checks.
module tb_traffic_ctrl_param;

    localparam int HW_MIN = 8;
    localparam int YEL    = 3;
    localparam int AR     = 1;
    localparam int SWMIN  = 4;
    localparam int SWMAX  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       veh = 1'b0;
    logic       hwr, hwy, hwg, swr, swy, swg;
    logic [2:0] phase;
    logic       cycle_done;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic       night = 1'b0;
`endif

    always #5 clk = ~clk;

    traffic_ctrl_param dut (
        .clk        (clk),
        .rst        (rst),
        .veh        (veh),
`ifdef TRAFFIC_NIGHT_FLASH_EN
        .night      (night),
`endif
        .hwr        (hwr),
        .hwy        (hwy),
        .hwg        (hwg),
        .swr        (swr),
        .swy        (swy),
        .swg        (swg),
        .phase      (phase),
        .cycle_done (cycle_done)
    );

    typedef struct {
        int         ph;
        logic [5:0] lights;
        logic       cd;
    } exp_t;

    typedef struct {
        int ph;
        int len;
    } run_t;

    exp_t expq[$];
    run_t runs[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   track_start = 1'b0;
    int   cur_ph  = 0;
    int   cur_len = 0;

    // Reference model: phase index, time spent in it, pending side request.
    int m_phase = 0;
    int m_t     = 0;
    bit m_req   = 1'b0;
    bit m_cd    = 1'b0;

    function automatic logic [5:0] light_of(int p);
        case (p)
            0:       return 6'b001100;
            1:       return 6'b010100;
            3:       return 6'b100001;
            4:       return 6'b100010;
            default: return 6'b100100;
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit v);
        bit lv;
        if (r) begin
            m_phase = 0; m_t = 0; m_req = 1'b0; m_cd = 1'b0;
            return;
        end
        case (m_phase)
            0:       lv = (m_t >= HW_MIN - 1) && (m_req || v);
            1, 4:    lv = (m_t == YEL - 1);
            2, 5:    lv = (m_t == AR - 1);
            default: lv = ((m_t >= SWMIN - 1) && !v) || (m_t == SWMAX - 1);
        endcase
        m_cd = (m_phase == 5) && lv;
        if (m_phase == 2 && lv) m_req = 1'b0;
        else if (v && m_phase != 3) m_req = 1'b1;
        if (lv) begin
            m_phase = (m_phase + 1) % 6;
            m_t     = 0;
        end else begin
            m_t = m_t + 1;
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge(rst, veh);
        e.ph     = m_phase;
        e.lights = light_of(m_phase);
        e.cd     = m_cd;
        expq.push_back(e);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        track_start = 1'b1;
    endtask

    task automatic pulse_veh();
        veh = 1'b1;
        step();
        veh = 1'b0;
    endtask

    task automatic wait_model(input int p, input int t);
        int n = 0;
        while (!(m_phase == p && m_t == t) && n < 200) begin
            step();
            n++;
        end
        compared++;
        if (n >= 200) begin
            mismatched++;
            $display("FAIL wait_phase: model never reached phase=%0d t=%0d, got phase=%0d t=%0d", p, t, m_phase, m_t);
        end
    endtask

    task automatic check_run(input string name, input int idx, input int p, input int len);
        compared++;
        if (idx >= runs.size()) begin
            mismatched++;
            $display("FAIL %s: run %0d missing (only %0d runs), required phase=%0d len=%0d", name, idx, runs.size(), p, len);
        end else if (runs[idx].ph != p || runs[idx].len != len) begin
            mismatched++;
            $display("FAIL %s: run %0d got phase=%0d len=%0d, required phase=%0d len=%0d",
                     name, idx, runs[idx].ph, runs[idx].len, p, len);
        end
    endtask

    task automatic check_no_change(input string name);
        compared++;
        if (runs.size() != 0) begin
            mismatched++;
            $display("FAIL %s: got %0d phase changes, required 0 (first left phase=%0d)", name, runs.size(), runs[0].ph);
        end
    endtask

    // Monitor: compare every output cycle against the scoreboard and track phase run lengths.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            compared++;
            if (phase != 3'(e.ph) || {hwr, hwy, hwg, swr, swy, swg} != e.lights || cycle_done != e.cd) begin
                mismatched++;
                $display("FAIL scoreboard @%0t: got phase=%0d lights=%b cd=%b, expected phase=%0d lights=%b cd=%b",
                         $time, phase, {hwr, hwy, hwg, swr, swy, swg}, cycle_done, e.ph, e.lights, e.cd);
            end
            compared++;
            if ((int'(hwr) + int'(hwy) + int'(hwg)) > 1 || (int'(swr) + int'(swy) + int'(swg)) > 1 || (hwg && swg)) begin
                mismatched++;
                $display("FAIL invariant @%0t: lights=%b, required at most one per road and not both green",
                         $time, {hwr, hwy, hwg, swr, swy, swg});
            end
            if (track_start) begin
                runs.delete();
                cur_ph      = int'(phase);
                cur_len     = 1;
                track_start = 1'b0;
            end else if (int'(phase) == cur_ph) begin
                cur_len++;
            end else begin
                runs.push_back('{cur_ph, cur_len});
                cur_ph  = int'(phase);
                cur_len = 1;
            end
        end
    end

    initial begin
        int prob;
        // Reset then 50 idle cycles: highway green holds, no pulse.
        rst = 1'b1;
        step();
        do_reset();
        repeat (50) step();
        check_no_change("idle_hold");

        // Single-cycle request at cnt=2 with default timing.
        do_reset();
        step();
        step();
        pulse_veh();
        repeat (25) step();
        check_run("pulse_hw_green", 0, 0, 8);
        check_run("pulse_hw_yellow", 1, 1, 3);
        check_run("pulse_all_red_a", 2, 2, 1);
        check_run("pulse_sw_green", 3, 3, 4);
        check_run("pulse_sw_yellow", 4, 4, 3);
        check_run("pulse_all_red_b", 5, 5, 1);

        // Vehicle sensor held high: side green capped, next cycle after minimum highway green.
        do_reset();
        veh = 1'b1;
        repeat (40) step();
        veh = 1'b0;
        check_run("held_sw_green_max", 3, 3, 10);
        check_run("held_hw_green_restart", 6, 0, 8);

        // Side green extended by arrivals at cnt 0..5.
        do_reset();
        pulse_veh();
        wait_model(3, 0);
        veh = 1'b1;
        repeat (6) step();
        veh = 1'b0;
        repeat (12) step();
        check_run("extend_sw_green", 3, 3, 7);

        // Request during side yellow is latched and served after minimum highway green.
        do_reset();
        pulse_veh();
        wait_model(4, 1);
        pulse_veh();
        repeat (20) step();
        check_run("late_req_hw_green", 6, 0, 8);
        check_run("late_req_hw_yellow", 7, 1, 3);

        // Reset in side green at cnt=2 returns to highway green.
        do_reset();
        pulse_veh();
        wait_model(3, 2);
        do_reset();
        repeat (20) step();
        check_no_change("reset_mid_sw_green");

        // Reset discards a pending request latched during highway green.
        do_reset();
        pulse_veh();
        step();
        do_reset();
        repeat (20) step();
        check_no_change("reset_discards_req");

        // Randomized traffic with varying density and occasional resets.
        prob = 20;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) prob = int'($urandom_range(0, 100));
            veh = (int'($urandom_range(0, 99)) < prob);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        veh = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
